board_input_ctrl: RTL
=====================

Name: board_input_ctrl

Overview:
- Parametrised, CPU-readable input controller for the MyComputer board switches and keys (SW/KEY), replacing the direct wiring of raw switch levels into the core.
- Per channel:
  - 2-flop synchroniser
  - polarity correction
  - counter-based debouncer
  - sticky rising-edge event capture
- Results are exposed through a small register interface on the MyComputer data bus.

Parameters:
- NUM_CH, 14, number of input channels (1..32); default covers SW[9:0] plus KEY[3:0].
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised input must differ from the stable value before the stable value updates (>=1). Board builds use 500000.
- ACTIVE_LOW_MASK, 14'h3C00, bit i = 1 inverts channel i (KEY is active-low).
- DATA_W, 32, width of the register data bus.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- raw_in  in  NUM_CH  unsynchronised board inputs
- addr  in  2  register word address
- wr  in  1  write strobe, 1 cycle
- wdata  in  DATA_W  write data
- rd  in  1  read strobe, 1 cycle
- rdata  out  DATA_W  registered read data
- rvalid  out  1  high for 1 cycle when rdata is valid
- stable_out  out  NUM_CH  debounced, polarity-corrected levels (for LEDR)
- irq  out  1  interrupt request (INPUT_IRQ_EN only; tied 0 otherwise)

Behaviour:
- Reset (async assert, sync release):
  - sync flops, stable, counters, events, mask, rdata, rvalid and irq all clear to 0.
  - Counters restart immediately.
- Synchroniser:
  - s1 <= raw_in ^ ACTIVE_LOW_MASK; s2 <= s1.
  - Polarity is applied before synchronisation.
- Debounce, per channel i:
  - If s2[i] == stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= s2[i] and cnt[i] <= 0.
  - Else cnt[i] <= cnt[i]+1.
  - Counter width: clog2(DEBOUNCE_CYCLES)+1.
- Debounce latency and glitch rejection:
  - A clean input change first sampled at edge k appears on stable_out after edge k+1+DEBOUNCE_CYCLES.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles at s2 resets the count and is rejected.
- Event capture:
  - events[i] sets on the same edge that stable[i] goes 0->1.
  - Falling transitions do not set events.
- Register map (reads return zeros above NUM_CH):
  - 0 = STATE: stable, read-only.
  - 1 = EVENTS: read; write-1-to-clear.
  - 2 = IRQ_MASK: RW with INPUT_IRQ_EN, otherwise reads 0 and writes are ignored.
  - 3 = CONFIG: read-only, {DEBOUNCE_CYCLES[23:0], NUM_CH[7:0]}.
- Reads:
  - rd at edge k gives rdata/rvalid valid after edge k+1; rvalid is a single pulse.
  - rdata holds its value until the next read.
  - Writes to read-only addresses are ignored.
  - Simultaneous rd and wr to the same address: the read returns the pre-write value.
- Boundaries:
  - Event set and W1C clear of the same bit on the same edge: set wins, bit stays 1.
  - Writes of 0 bits leave events unchanged.
  - DEBOUNCE_CYCLES=1: stable follows s2 with 1 cycle lag.
  - Reset mid-count discards the count; no event is generated by reset.

Optional Feature:
- Macro INPUT_IRQ_EN.
- Defined:
  - IRQ_MASK register implemented.
  - irq is registered and equals |(events & mask), one cycle after the contributing event/mask change.
  - irq clears the cycle after the last masked event is cleared.
- Undefined:
  - No mask flops; irq constant 0.
  - Address 2 reads 0.

Decomposition:
- Shared package board_io_pkg:
  - register address constants ADDR_STATE/ADDR_EVENTS/ADDR_MASK/ADDR_CONFIG
  - DATA_W default
  - board channel index constants (SW0..SW9, KEY0..KEY3)
- Sub-module input_debounce: one channel containing sync, counter and stable bit, instantiated NUM_CH times by generate.
- Top level holds the event, mask and read/write logic.

Test Plan (DEBOUNCE_CYCLES=4, default NUM_CH and mask):
- Reset:
  - Stimulus: assert reset with SW=0 and KEY=4'hF (released), then drop it.
  - Required: stable_out = 0 and EVENTS reads 0.
- Debounce latency:
  - Stimulus: SW[8] 0->1, sampled at edge 10.
  - Required: stable_out[8] = 1 after edge 15 (not before); EVENTS bit 8 = 1 on the same edge.
- Glitch rejection:
  - Stimulus: pulse KEY[0] low for 3 cycles.
  - Required: stable_out[10] never changes; EVENTS = 0.
- W1C:
  - Stimulus: events = 0x0100; write 0x0100 to addr 1.
  - Required: the next read of addr 1 returns 0.
- Set-vs-clear collision:
  - Stimulus: W1C of bit 8 on the same edge stable[8] rises again.
  - Required: read returns 0x0100.
- Interrupts (INPUT_IRQ_EN):
  - Stimulus: mask = 0x0400, then press KEY[0].
  - Required: irq = 1 one cycle after EVENTS bit 10 sets; W1C 0x0400 drops irq next cycle.
  - Stimulus: set mask = 0.
  - Required: irq stays 0 on new events.

Source files
------------

// File: rtl/board_io_pkg.sv
// board_io_pkg: shared constants for the MyComputer board input controller.
//   - register word addresses (STATE, EVENTS, IRQ_MASK, CONFIG)
//   - default data bus width
//   - channel index constants for SW[9:0] and KEY[3:0]
//   - helper that packs the read-only CONFIG word
package board_io_pkg;

   localparam int DATA_W_DEF = 32;

   localparam logic [1:0] ADDR_STATE  = 2'd0;
   localparam logic [1:0] ADDR_EVENTS = 2'd1;
   localparam logic [1:0] ADDR_MASK   = 2'd2;
   localparam logic [1:0] ADDR_CONFIG = 2'd3;

   localparam int SW0  = 0;
   localparam int SW1  = 1;
   localparam int SW2  = 2;
   localparam int SW3  = 3;
   localparam int SW4  = 4;
   localparam int SW5  = 5;
   localparam int SW6  = 6;
   localparam int SW7  = 7;
   localparam int SW8  = 8;
   localparam int SW9  = 9;
   localparam int KEY0 = 10;
   localparam int KEY1 = 11;
   localparam int KEY2 = 12;
   localparam int KEY3 = 13;

   // CONFIG word layout: {debounce cycles[23:0], channel count[7:0]}
   function automatic logic [31:0] config_word(input int unsigned dcycles, input int unsigned nch);
      logic [31:0] dc_v;
      logic [31:0] nch_v;
      dc_v  = 32'(dcycles);
      nch_v = 32'(nch);
      return {dc_v[23:0], nch_v[7:0]};
   endfunction

endpackage

// File: rtl/board_input_ctrl_if.sv
// board_input_ctrl_if: register bus between the CPU side and the input controller.
//   addr   : register word address (master -> slave)
//   wr     : 1-cycle write strobe   (master -> slave)
//   wdata  : write data             (master -> slave)
//   rd     : 1-cycle read strobe    (master -> slave)
//   rdata  : registered read data   (slave -> master)
//   rvalid : 1-cycle rdata valid    (slave -> master)
interface board_input_ctrl_if
   import board_io_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
);
   logic [1:0]        addr;
   logic              wr;
   logic [DATA_W-1:0] wdata;
   logic              rd;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;

   modport master (output addr, output wr, output wdata, output rd,
                   input  rdata, input rvalid);
   modport slave  (input  addr, input  wr, input  wdata, input  rd,
                   output rdata, output rvalid);
endinterface

// File: rtl/input_debounce.sv
// input_debounce: one input channel.
//   2-flop synchroniser (polarity applied before it), counter debouncer, stable bit.
//   clk, reset  : clock, async active-high reset
//   raw_in      : unsynchronised board input
//   stable_out  : debounced, polarity-corrected level (registered)
//   rise_out    : high in the cycle whose closing edge takes stable 0->1
module input_debounce #(
   parameter int   DEBOUNCE_CYCLES = 4,
   parameter logic INVERT          = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_in,
   output logic stable_out,
   output logic rise_out
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_r;
   logic             s2_r;
   logic             stable_r;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             stable_nxt_s;

   // Next-state of the debounce counter and stable level
   always_comb begin
      cnt_nxt_s    = cnt_r;
      stable_nxt_s = stable_r;
      if (s2_r == stable_r) begin
         cnt_nxt_s = '0;
      end else if (cnt_r == CNT_LAST) begin
         stable_nxt_s = s2_r;
         cnt_nxt_s    = '0;
      end else begin
         cnt_nxt_s = cnt_r + CNT_W'(1);
      end
   end

   // Synchroniser, counter and stable level registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_r     <= 1'b0;
         s2_r     <= 1'b0;
         stable_r <= 1'b0;
         cnt_r    <= '0;
      end else begin
         s1_r     <= raw_in ^ INVERT;
         s2_r     <= s1_r;
         stable_r <= stable_nxt_s;
         cnt_r    <= cnt_nxt_s;
      end
   end

   assign stable_out = stable_r;
   // Combinational so the top can set the event on the same edge stable rises
   assign rise_out   = stable_nxt_s & ~stable_r;

endmodule

// File: rtl/board_input_ctrl.sv
// board_input_ctrl: CPU-readable controller for the board switches and keys.
//   clk, reset  : clock, async active-high reset
//   raw_in      : unsynchronised SW/KEY levels
//   bus         : register slave port (STATE, EVENTS w1c, IRQ_MASK, CONFIG)
//   stable_out  : debounced, polarity-corrected levels
//   irq         : |(events & mask), registered
// Optional feature macro INPUT_IRQ_EN: when undefined there are no mask flops,
// address 2 reads 0 and irq is tied low.
module board_input_ctrl
   import board_io_pkg::*;
#(
   parameter int          NUM_CH          = 14,
   parameter int          DEBOUNCE_CYCLES = 4,
   parameter logic [31:0] ACTIVE_LOW_MASK = 32'h0000_3C00,
   parameter int          DATA_W          = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] raw_in,
   board_input_ctrl_if.slave bus,
   output logic [NUM_CH-1:0] stable_out,
   output logic              irq
);

   localparam logic [31:0] CONFIG_WORD = config_word(DEBOUNCE_CYCLES, NUM_CH);

   logic [NUM_CH-1:0] stable_s;
   logic [NUM_CH-1:0] rise_s;
   logic [NUM_CH-1:0] w1c_s;
   logic [NUM_CH-1:0] events_r;
   logic [DATA_W-1:0] rd_word_s;
   logic [DATA_W-1:0] rdata_r;
   logic              rvalid_r;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      input_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .INVERT          (ACTIVE_LOW_MASK[gi])
      ) u_deb (
         .clk        (clk),
         .reset      (reset),
         .raw_in     (raw_in[gi]),
         .stable_out (stable_s[gi]),
         .rise_out   (rise_s[gi])
      );
   end

   assign stable_out = stable_s;

   // Write-1-to-clear bits for EVENTS
   always_comb begin
      w1c_s = '0;
      if (bus.wr && (bus.addr == ADDR_EVENTS)) begin
         w1c_s = bus.wdata[NUM_CH-1:0];
      end else begin
         w1c_s = '0;
      end
   end

   // Sticky rising-edge events; a rise on the same edge as a clear wins
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         events_r <= '0;
      end else begin
         events_r <= (events_r & ~w1c_s) | rise_s;
      end
   end

`ifdef INPUT_IRQ_EN
   logic [NUM_CH-1:0] mask_r;
   logic              irq_r;

   // Interrupt mask register and registered interrupt request
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask_r <= '0;
         irq_r  <= 1'b0;
      end else begin
         if (bus.wr && (bus.addr == ADDR_MASK)) begin
            mask_r <= bus.wdata[NUM_CH-1:0];
         end
         irq_r <= |(events_r & mask_r);
      end
   end

   assign irq = irq_r;
`else
   assign irq = 1'b0;
`endif

   // Read mux over pre-edge register values, zero above NUM_CH
   always_comb begin
      rd_word_s = '0;
      case (bus.addr)
         ADDR_STATE:  rd_word_s[NUM_CH-1:0] = stable_s;
         ADDR_EVENTS: rd_word_s[NUM_CH-1:0] = events_r;
`ifdef INPUT_IRQ_EN
         ADDR_MASK:   rd_word_s[NUM_CH-1:0] = mask_r;
`else
         ADDR_MASK:   rd_word_s = '0;
`endif
         ADDR_CONFIG: rd_word_s = DATA_W'(CONFIG_WORD);
         default:     rd_word_s = '0;
      endcase
   end

   // Registered read data (held between reads) and single-cycle valid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_r  <= '0;
         rvalid_r <= 1'b0;
      end else begin
         rvalid_r <= bus.rd;
         if (bus.rd) begin
            rdata_r <= rd_word_s;
         end
      end
   end

   assign bus.rdata  = rdata_r;
   assign bus.rvalid = rvalid_r;

endmodule
